// File: rtl/pattern_tx.sv
// pattern_tx: framed serial pattern generator "1, g zeros, 1, guard zeros" with optional one-entry skid buffer (PATTERN_TX_SKID_EN)
module pattern_tx #(
  parameter int GAP_W     = 3,
  parameter int MAX_GAP   = 6,
  parameter int GUARD_LEN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [GAP_W-1:0] req_gap,
  output logic             req_ready,
  output logic             x,
  output logic             busy,
  output logic             done
);
  localparam int MX = (MAX_GAP > GUARD_LEN) ? MAX_GAP : GUARD_LEN;
  localparam int CW = (MX < 1) ? 1 : $clog2(MX + 1);
  typedef enum logic [2:0] {IDLE, LEAD, GAP, TAIL, GUARD} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, g_in, start_gap;
  logic fsm_ready, take, x_n;
  assign g_in = (int'(req_gap) > MAX_GAP) ? CW'(MAX_GAP) : CW'(req_gap);
  assign busy = state != IDLE;
  assign done = state == GUARD && cnt == '0;
  assign fsm_ready = state == IDLE || done;
`ifdef PATTERN_TX_SKID_EN
  logic sb_v;
  logic [CW-1:0] sb_gap;
  assign req_ready = !sb_v;
  assign take = fsm_ready && (sb_v || req_valid);
  assign start_gap = sb_v ? sb_gap : g_in;
  // pending buffer: capture a request the FSM cannot take yet, release it at frame end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sb_v   <= 1'b0;
      sb_gap <= '0;
    end else if (req_valid && !sb_v && !fsm_ready) begin
      sb_v   <= 1'b1;
      sb_gap <= g_in;
    end else if (sb_v && fsm_ready) sb_v <= 1'b0;
`else
  assign req_ready = fsm_ready;
  assign take = req_valid && fsm_ready;
  assign start_gap = g_in;
`endif
  // next state: cnt holds remaining cycles minus one in GAP and GUARD; LEAD holds the full gap
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: ;
      LEAD: begin
        state_n = (cnt == '0) ? TAIL : GAP;
        cnt_n   = (cnt == '0) ? cnt : cnt - CW'(1);
      end
      GAP: begin
        state_n = (cnt == '0) ? TAIL : GAP;
        cnt_n   = (cnt == '0) ? cnt : cnt - CW'(1);
      end
      TAIL: begin
        state_n = GUARD;
        cnt_n   = CW'(GUARD_LEN - 1);
      end
      GUARD: begin
        state_n = (cnt == '0) ? IDLE : GUARD;
        cnt_n   = (cnt == '0) ? cnt : cnt - CW'(1);
      end
      default: state_n = IDLE;
    endcase
    if (take) begin
      state_n = LEAD;
      cnt_n   = start_gap;
    end
    x_n = state_n == LEAD || state_n == TAIL;
  end
  // state, counter and registered serial line; reset clears x without a clock edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      x     <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      x     <= x_n;
    end
endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: directed scoreboard bench for pattern_tx (serial stream, busy, done, ready, async reset)
module tb_pattern_tx;
  localparam int MAX_GAP = 6;
  localparam int GUARD = 1;
  typedef struct packed {logic x; logic busy; logic done;} exp_t;
  logic clk = 1'b0;
  logic rst, req_valid, req_ready, x, busy, done;
  logic [2:0] req_gap;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int n;

  pattern_tx #(.GAP_W(3), .MAX_GAP(MAX_GAP), .GUARD_LEN(GUARD)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_gap(req_gap),
    .req_ready(req_ready), .x(x), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: one expected {x,busy,done} per cycle, compared 1 time unit after each edge
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("stream{x,busy,done}", {5'b0, x, busy, done}, {5'b0, e});
    end
  end

  task automatic push_frame(input int g);
    int gg = (g > MAX_GAP) ? MAX_GAP : g;
    q.push_back('{1'b1, 1'b1, 1'b0});
    repeat (gg) q.push_back('{1'b0, 1'b1, 1'b0});
    q.push_back('{1'b1, 1'b1, 1'b0});
    for (int i = 0; i < GUARD; i++) q.push_back('{1'b0, 1'b1, i == GUARD - 1});
  endtask

  task automatic push_idle(input int k);
    repeat (k) q.push_back('{1'b0, 1'b0, 1'b0});
  endtask

  task automatic drain();
    int b = 0;
    while (q.size() > 0 && b < 200) begin
      @(posedge clk);
      #2;
      b++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", 8'(q.size()), 8'd0);
      q.delete();
    end
  endtask

  // drive a request with its expected frame, return edges taken until the transfer
  task automatic send(input int g, output int waits);
    logic rdy;
    waits = 0;
    req_valid = 1'b1;
    req_gap = 3'(g);
    push_frame(g);
    do begin
      rdy = req_ready;
      @(posedge clk);
      #2;
      waits++;
    end while (!rdy && waits < 50);
    if (!rdy) chk("handshake_timeout", 8'(rdy), 8'd1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_gap = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_x", 8'(x), 8'd0);
    chk("reset_busy", 8'(busy), 8'd0);
    chk("reset_done", 8'(done), 8'd0);
    chk("reset_ready", 8'(req_ready), 8'd1);
    rst = 1'b0;
    push_idle(2);
    drain();
    // single frame, gap=1
    send(1, n);
    chk("single_accept_wait", 8'(n), 8'd1);
    req_valid = 1'b0;
    push_idle(2);
    drain();
    // back-to-back gap=2 then gap=3 with valid held
    send(2, n);
    send(3, n);
`ifdef PATTERN_TX_SKID_EN
    chk("b2b_wait_skid", 8'(n), 8'd1);
`else
    chk("b2b_wait_ready_low", 8'(n), 8'd5);
`endif
    req_valid = 1'b0;
    push_idle(2);
    drain();
    // gap=0 and clamped gap=7
    send(0, n);
    req_valid = 1'b0;
    push_idle(1);
    drain();
    send(7, n);
    req_valid = 1'b0;
    push_idle(2);
    drain();
    // reset during GAP of a gap=3 frame
    req_valid = 1'b1;
    req_gap = 3'd3;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_busy", 8'(busy), 8'd1);
    chk("pre_rst_x_gap", 8'(x), 8'd0);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 8'(busy), 8'd0);
    chk("async_rst_x", 8'(x), 8'd0);
    chk("async_rst_done", 8'(done), 8'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    push_idle(3);
    drain();
    // reset during LEAD drops x at once
    req_valid = 1'b1;
    req_gap = 3'd2;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    chk("lead_x", 8'(x), 8'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_lead_x", 8'(x), 8'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    push_idle(2);
    drain();
    // clean frame after reset
    send(3, n);
    req_valid = 1'b0;
    push_idle(2);
    drain();
`ifdef PATTERN_TX_SKID_EN
    // skid: second request buffered during the first frame
    send(1, n);
    send(2, n);
    chk("skid_accept_wait", 8'(n), 8'd1);
    req_valid = 1'b0;
    chk("skid_full_ready", 8'(req_ready), 8'd0);
    push_idle(2);
    drain();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
